// File: rtl/bf_pkg.sv
// Shared types and helpers for the weight fetch sequencer.
// Bitwidth codes, FSM states and phases-per-word lookup.
package bf_pkg;

  localparam logic [1:0] BW_8 = 2'b00;
  localparam logic [1:0] BW_4 = 2'b01;
  localparam logic [1:0] BW_2 = 2'b10;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_REQ,
    FSM_WAIT,
    FSM_STREAM,
    FSM_DONE
  } fsm_e;

  // 2'b11 is treated as 2-bit as well
  function automatic logic [2:0] phases_per_bw(input logic [1:0] bw);
    logic [2:0] n;
    case (bw)
      BW_8:    n = 3'd1;
      BW_4:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/weight_phase_cnt.sv
// Phase-within-word and remaining-word counter.
// Flags the last phase of a word and the final word of a block.
module weight_phase_cnt
  import bf_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [1:0]        bw_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic              step_i,
  output logic [1:0]        phase_o,
  output logic              last_phase_o,
  output logic              last_word_o
);

  logic [1:0]        bw_q, bw_d;
  logic [1:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [2:0]        nph;
  logic [1:0]        last_idx;

  assign nph          = phases_per_bw(bw_q);
  assign last_idx     = 2'(nph - 3'd1);
  assign last_phase_o = (phase_q == last_idx);
  assign last_word_o  = (rem_q == '0);
  assign phase_o      = phase_q;

  always_comb begin
    bw_d    = bw_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    if (load_i) begin
      bw_d    = bw_i;
      phase_d = 2'd0;
      rem_d   = count_i - ADDR_W'(1);
    end else if (step_i) begin
      if (last_phase_o) begin
        phase_d = 2'd0;
        if (!last_word_o) begin
          rem_d = rem_q - ADDR_W'(1);
        end
      end else begin
        phase_d = phase_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bw_q    <= BW_8;
      phase_q <= 2'd0;
      rem_q   <= '0;
    end else begin
      bw_q    <= bw_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: rtl/weight_fetch_seq.sv
// Weight-buffer fetch sequencer: reads a block of words and
// presents each word for 1/2/4 phases to the downstream MUX.
module weight_fetch_seq
  import bf_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [1:0]        input_bitwidth,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] buffer,
  output logic [1:0]        state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  fsm_e              fsm_q, fsm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load, step, xfer;
  logic              last_phase, last_word;

  weight_phase_cnt #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (reset),
    .load_i       (load),
    .bw_i         (input_bitwidth),
    .count_i      (word_count),
    .step_i       (step),
    .phase_o      (state),
    .last_phase_o (last_phase),
    .last_word_o  (last_word)
  );

  assign xfer = vld_q & out_ready;

  always_comb begin
    fsm_d  = fsm_q;
    addr_d = addr_q;
    en_d   = 1'b0;
    buf_d  = buf_q;
    vld_d  = vld_q;
    done_d = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    unique case (fsm_q)
      FSM_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            load   = 1'b1;
            addr_d = base_addr;
            en_d   = 1'b1;
            fsm_d  = FSM_REQ;
          end else begin
            fsm_d  = FSM_DONE;
          end
        end
      end
      FSM_REQ: begin
        fsm_d = FSM_WAIT;
      end
      FSM_WAIT: begin
        buf_d = mem_rdata;
        vld_d = 1'b1;
        fsm_d = FSM_STREAM;
      end
      FSM_STREAM: begin
        if (xfer) begin
          step = 1'b1;
          if (last_phase) begin
            vld_d = 1'b0;
            if (last_word) begin
              fsm_d = FSM_DONE;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              en_d   = 1'b1;
              fsm_d  = FSM_REQ;
            end
          end
        end
      end
      FSM_DONE: begin
        done_d = 1'b1;
        fsm_d  = FSM_IDLE;
      end
      default: begin
        fsm_d = FSM_IDLE;
        vld_d = 1'b0;
      end
    endcase
    busy_d = (fsm_d != FSM_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q  <= FSM_IDLE;
      addr_q <= '0;
      en_q   <= 1'b0;
      buf_q  <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      addr_q <= addr_d;
      en_q   <= en_d;
      buf_q  <= buf_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign mem_en    = en_q;
  assign mem_addr  = addr_q;
  assign buffer    = buf_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Self-checking bench for weight_fetch_seq: block table,
// corner-case sequences and random blocks vs a transaction model.
module tb_weight_fetch_seq;

  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic [1:0]    input_bitwidth;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   buffer;
  logic [1:0]    state;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  weight_fetch_seq #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .input_bitwidth (input_bitwidth),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .buffer         (buffer),
    .state          (state),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level expectations
  logic [AW-1:0] exp_addr[$];
  logic [33:0]   exp_xfer[$];
  int            exp_done = 0;
  int            done_seen = 0;
  int            xfer_cnt = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_buf;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_en) begin
        if (exp_addr.size() == 0) begin
          check("spurious_mem_en", 64'(mem_addr), 64'hDEAD);
        end else begin
          check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
          last_addr = mem_addr;
        end
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        last_buf = buffer;
        if (exp_xfer.size() == 0) begin
          check("spurious_xfer", {30'd0, state, buffer}, 64'hDEAD);
        end else begin
          check("xfer_buf_state", {30'd0, buffer, state},
                64'(exp_xfer.pop_front()));
        end
      end
      if (done) begin
        done_seen++;
        check("done_expected", 64'(exp_done > 0), 64'd1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  function automatic int nphases(input int bw);
    if (bw == 0) return 1;
    if (bw == 1) return 2;
    return 4;
  endfunction

  task automatic launch(input int b, input int c, input int bw);
    for (int w = 0; w < c; w++) begin
      int a;
      a = (b + w) % DEPTH;
      exp_addr.push_back(AW'(a));
      for (int p = 0; p < nphases(bw); p++) begin
        exp_xfer.push_back({mem[a], 2'(p)});
      end
    end
    exp_done++;
    @(posedge clk); #1;
    base_addr      = AW'(b);
    word_count     = AW'(c);
    input_bitwidth = 2'(bw);
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input bit rnd_ready,
                           input bit junk);
    for (int i = 0; i < 3000 && done_seen < target; i++) begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk) begin
        base_addr      = AW'($urandom);
        word_count     = AW'($urandom);
        input_bitwidth = 2'($urandom);
        start          = busy && ($urandom_range(0, 2) == 0);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_count", 64'(done_seen), 64'(target));
    check("leftover_addr", 64'(exp_addr.size()), 64'd0);
    check("leftover_xfer", 64'(exp_xfer.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int i;
    i = 0;
    while (!out_valid && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("wait_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_buffer"}, 64'(buffer), 64'd0);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    int base;
    int count;
    int bw;
    bit rnd;
    int exp_xfers;
    int exp_last;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] hold_buf;
    int snap;

    tbl[0] = '{5, 2, 0, 1'b0, 2, 6};
    tbl[1] = '{1023, 2, 1, 1'b0, 4, 0};
    tbl[2] = '{0, 3, 3, 1'b1, 12, 2};
    tbl[3] = '{100, 1, 2, 1'b1, 4, 100};
    tbl[4] = '{1022, 4, 1, 1'b1, 8, 1};

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem_rdata      = '0;
    reset          = 1'b0;
    start          = 1'b0;
    base_addr      = '0;
    word_count     = '0;
    input_bitwidth = '0;
    out_ready      = 1'b1;

    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Table of blocks
    for (int t = 0; t < 5; t++) begin
      xfer_cnt = 0;
      launch(tbl[t].base, tbl[t].count, tbl[t].bw);
      wait_done(done_seen + 1, tbl[t].rnd, tbl[t].rnd);
      check("tbl_xfers", 64'(xfer_cnt), 64'(tbl[t].exp_xfers));
      check("tbl_last_addr", 64'(last_addr), 64'(tbl[t].exp_last));
    end

    // Latency: mem_en in cycle 1, out_valid from cycle 3
    launch(7, 1, 0);
    check("lat_c1_mem_en", 64'(mem_en), 64'd1);
    check("lat_c1_addr", 64'(mem_addr), 64'd7);
    check("lat_c1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("lat_c2_mem_en", 64'(mem_en), 64'd0);
    check("lat_c2_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_c3_valid", 64'(out_valid), 64'd1);
    check("lat_c3_buf", 64'(buffer), 64'(mem[7]));
    wait_done(done_seen + 1, 1'b0, 1'b0);

    // Scenario 2: single 4-bit word with known data
    mem[30] = 32'hA1B2C3D4;
    xfer_cnt = 0;
    launch(30, 1, 1);
    wait_done(done_seen + 1, 1'b0, 1'b0);
    check("s2_xfers", 64'(xfer_cnt), 64'd2);
    check("s2_buf", 64'(last_buf), 64'hA1B2C3D4);

    // Zero-length block: done two cycles after start
    snap = done_seen;
    launch(9, 0, 0);
    check("z_c1_done", 64'(done), 64'd0);
    check("z_c1_busy", 64'(busy), 64'd1);
    check("z_c1_mem_en", 64'(mem_en), 64'd0);
    @(posedge clk); #1;
    check("z_c2_done", 64'(done), 64'd1);
    check("z_c2_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("z_c3_done", 64'(done), 64'd0);
    check("z_done_once", 64'(done_seen), 64'(snap + 1));

    // Stall in phase 2 of a 2-bit word
    out_ready = 1'b0;
    xfer_cnt = 0;
    launch(40, 1, 2);
    wait_valid();
    check("st_ph0", 64'(state), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("st_ph1", 64'(state), 64'd1);
    @(posedge clk); #1;
    check("st_ph2", 64'(state), 64'd2);
    out_ready = 1'b0;
    hold_buf = buffer;
    repeat (3) begin
      @(posedge clk); #1;
      check("st_hold_state", 64'(state), 64'd2);
      check("st_hold_buf", 64'(buffer), 64'(hold_buf));
      check("st_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    wait_done(done_seen + 1, 1'b0, 1'b0);
    check("st_xfers", 64'(xfer_cnt), 64'd4);

    // Start while busy must not alter the running block
    xfer_cnt = 0;
    launch(300, 2, 1);
    wait_valid();
    base_addr      = AW'(50);
    word_count     = AW'(5);
    input_bitwidth = 2'd0;
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(done_seen + 1, 1'b0, 1'b0);
    check("busy_start_xfers", 64'(xfer_cnt), 64'd4);
    check("busy_start_last", 64'(last_addr), 64'd301);

    // Reset mid-stream abandons the block
    snap = done_seen;
    launch(200, 3, 2);
    wait_valid();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_addr.delete();
    exp_xfer.delete();
    exp_done = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_seen), 64'(snap));
    check_zero("post_reset");

    // Random blocks with random backpressure and input noise
    for (int r = 0; r < 10; r++) begin
      int b, c, bw;
      b  = $urandom_range(0, DEPTH - 1);
      c  = $urandom_range(0, 4);
      bw = $urandom_range(0, 3);
      xfer_cnt = 0;
      launch(b, c, bw);
      wait_done(done_seen + 1, 1'b1, 1'b1);
      check("rnd_xfers", 64'(xfer_cnt), 64'(c * nphases(bw)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
